// File: rtl/mem_fill_engine.sv
// mem_fill_engine: claims the shared memory port, writes an identity, constant
// or descending pattern to DEPTH locations, optionally reads the array back to
// check it, and pulses done. Read-back verify is built when FILL_VERIFY_EN is
// defined; otherwise verify_err/err_addr stay 0 and rdata is ignored.
module mem_fill_engine #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned SEL_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fill_value,
    input  logic [SEL_W-1:0]  target_sel,
    output logic              busy,
    output logic              mem_req,
    output logic [SEL_W-1:0]  memory_sel,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] wdata,
    output logic              wen,
    input  logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              verify_err,
    output logic [ADDR_W-1:0] err_addr
);

    // One spare counter bit so DEPTH == 2**ADDR_W terminates without wrapping.
    localparam int unsigned      CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] VRD_END = CNT_W'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_VRD, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              verr_q, verr_d;
    logic [ADDR_W-1:0] eaddr_q, eaddr_d;
    logic              busy_q, busy_d;
    logic              mem_req_q, mem_req_d;
    logic [SEL_W-1:0]  msel_q, msel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wen_q, wen_d;
    logic              done_q, done_d;

    // Fill pattern for counter value c; mode 11 falls back to identity.
    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m,
                                                  input logic [DATA_W-1:0] v,
                                                  input logic [CNT_W-1:0] c);
        case (m)
            2'b01:   return v;
            2'b10:   return DATA_W'(LAST - c);
            default: return DATA_W'(c);
        endcase
    endfunction

`ifndef FILL_VERIFY_EN
    logic unused_rdata;
    assign unused_rdata = ^rdata;
`endif

    // Next state, counter, latched request and registered-output next values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        val_d   = val_q;
        sel_d   = sel_q;
        verr_d  = verr_q;
        eaddr_d = eaddr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FILL;
                    cnt_d   = '0;
                    mode_d  = mode;
                    val_d   = fill_value;
                    sel_d   = target_sel;
                    verr_d  = 1'b0;
                    eaddr_d = '0;
                end
            end
            S_FILL: begin
                if (cnt_q == LAST) begin
`ifdef FILL_VERIFY_EN
                    state_d = S_VRD;
                    cnt_d   = '0;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef FILL_VERIFY_EN
            S_VRD: begin
                // rdata answers the address presented one cycle earlier.
                if ((cnt_q != '0) && !verr_q &&
                    (rdata != pattern(mode_q, val_q, cnt_q - CNT_W'(1)))) begin
                    verr_d  = 1'b1;
                    eaddr_d = ADDR_W'(cnt_q - CNT_W'(1));
                end
                if (cnt_q == VRD_END) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d    = (state_d != S_IDLE);
        mem_req_d = (state_d == S_FILL) || (state_d == S_VRD);
        msel_d    = mem_req_d ? sel_d : '0;
        wen_d     = (state_d == S_FILL);
        done_d    = (state_d == S_DONE);
        addr_d    = '0;
        wdata_d   = '0;
        if (state_d == S_FILL) begin
            addr_d  = ADDR_W'(cnt_d);
            wdata_d = pattern(mode_d, val_d, cnt_d);
        end else if ((state_d == S_VRD) && (cnt_d != VRD_END)) begin
            addr_d  = ADDR_W'(cnt_d);
        end
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mode_q    <= '0;
            val_q     <= '0;
            sel_q     <= '0;
            verr_q    <= 1'b0;
            eaddr_q   <= '0;
            busy_q    <= 1'b0;
            mem_req_q <= 1'b0;
            msel_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wen_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            val_q     <= val_d;
            sel_q     <= sel_d;
            verr_q    <= verr_d;
            eaddr_q   <= eaddr_d;
            busy_q    <= busy_d;
            mem_req_q <= mem_req_d;
            msel_q    <= msel_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wen_q     <= wen_d;
            done_q    <= done_d;
        end
    end

    assign busy       = busy_q;
    assign mem_req    = mem_req_q;
    assign memory_sel = msel_q;
    assign address    = addr_q;
    assign wdata      = wdata_q;
    assign wen        = wen_q;
    assign done       = done_q;
    assign verify_err = verr_q;
    assign err_addr   = eaddr_q;

endmodule
